// File: rtl/apply_frontier_collect_pkg.sv
// Shared constants for the apply-path frontier collector: default geometry, FSM encodings and the
// almost-full threshold helper.
package apply_frontier_collect_pkg;

  localparam int unsigned AFC_V_ID_WIDTH      = 32;
  localparam int unsigned AFC_CORE_NUM        = 4;
  localparam int unsigned FRONTIER_FIFO_DEPTH = 16;
  localparam int unsigned FRONTIER_AF_MARGIN  = 4;
  localparam int unsigned AFC_CNT_WIDTH       = 32;
  localparam int unsigned AFC_ITER_WIDTH      = 16;

  localparam logic [1:0] FC_RUN   = 2'd0;
  localparam logic [1:0] FC_DRAIN = 2'd1;
  localparam logic [1:0] FC_DONE  = 2'd2;

  // A margin at or beyond the depth would make the threshold negative; clamp to stall-always.
  function automatic int unsigned af_threshold(input int unsigned depth,
                                               input int unsigned margin);
    return (margin >= depth) ? 0 : depth - margin;
  endfunction

endpackage

// File: rtl/apply_frontier_collect_lane.sv
// One lane of the frontier collector: updated-vertex FIFO, iteration FSM and counters.
// Optional stall-cycle counter is built only when APPLY_FRONTIER_STALL_CNT_EN is defined.
module apply_frontier_collect_lane
  import apply_frontier_collect_pkg::*;
#(
  parameter int unsigned V_ID_WIDTH = AFC_V_ID_WIDTH,
  parameter int unsigned FIFO_DEPTH = FRONTIER_FIFO_DEPTH,
  parameter int unsigned AF_MARGIN  = FRONTIER_AF_MARGIN,
  parameter int unsigned CNT_WIDTH  = AFC_CNT_WIDTH,
  parameter int unsigned ITER_WIDTH = AFC_ITER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [V_ID_WIDTH-1:0] active_v_id,
  input  logic                  active_v_updated,
  input  logic                  active_v_pull_first_flag,
  input  logic                  active_v_valid,
  input  logic                  iteration_end,
  input  logic                  iteration_end_valid,
  input  logic                  next_frontier_ready,
  output logic [V_ID_WIDTH-1:0] next_frontier_v_id,
  output logic                  next_frontier_pull_first_flag,
  output logic                  next_frontier_valid,
  output logic                  front_stall,
  output logic                  iteration_done,
  output logic [CNT_WIDTH-1:0]  iteration_update_cnt,
  output logic [ITER_WIDTH-1:0] iteration_num,
  output logic                  overflow_err,
  output logic [CNT_WIDTH-1:0]  stall_cycle_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AfCnt   = CntW'(af_threshold(FIFO_DEPTH, AF_MARGIN));

  logic [V_ID_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                front_stall_q, front_stall_d;
  logic                overflow_q, overflow_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_WIDTH-1:0]  upd_cnt_q, upd_cnt_d, upd_cnt_inc;
  logic [ITER_WIDTH-1:0] iter_num_q, iter_num_d;

  logic push, pop, full, push_ok, fifo_empty;
  logic [V_ID_WIDTH:0] head;

  assign push       = active_v_valid & active_v_updated;
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == FullCnt);
  assign pop        = ~fifo_empty & next_frontier_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    front_stall_d = (count_d >= AfCnt);
    overflow_d    = overflow_q | (push & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {active_v_pull_first_flag, active_v_id};
  end

  assign upd_cnt_inc = (upd_cnt_q == '1) ? upd_cnt_q : upd_cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    upd_cnt_d  = upd_cnt_q;
    iter_num_d = iter_num_q;
    case (state_q)
      FC_RUN: begin
        if (push_ok) upd_cnt_d = upd_cnt_inc;
        if (iteration_end_valid && iteration_end) state_d = FC_DRAIN;
      end
      FC_DRAIN: begin
        if (push_ok) upd_cnt_d = upd_cnt_inc;
        if (fifo_empty && !push) begin
          state_d    = FC_DONE;
          iter_num_d = iter_num_q + ITER_WIDTH'(1);
        end
      end
      FC_DONE: begin
        // The final count is on the output this cycle; a push now opens the next iteration.
        upd_cnt_d = push_ok ? CNT_WIDTH'(1) : '0;
        state_d   = FC_RUN;
      end
      default: state_d = FC_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      front_stall_q <= 1'b0;
      overflow_q    <= 1'b0;
      state_q       <= FC_RUN;
      upd_cnt_q     <= '0;
      iter_num_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      front_stall_q <= front_stall_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      upd_cnt_q     <= upd_cnt_d;
      iter_num_q    <= iter_num_d;
    end
  end

  // Head is masked while empty so the unreset storage never reaches the writer.
  assign head                          = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign next_frontier_v_id            = head[V_ID_WIDTH-1:0];
  assign next_frontier_pull_first_flag = head[V_ID_WIDTH];
  assign next_frontier_valid           = ~fifo_empty;
  assign front_stall                   = front_stall_q;
  assign iteration_done                = (state_q == FC_DONE);
  assign iteration_update_cnt          = upd_cnt_q;
  assign iteration_num                 = iter_num_q;
  assign overflow_err                  = overflow_q;

`ifdef APPLY_FRONTIER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (next_frontier_valid && !next_frontier_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycle_cnt = stall_cnt_q;
`else
  assign stall_cycle_cnt = '0;
`endif

endmodule

// File: rtl/apply_frontier_collect.sv
// Frontier collector top: one independent lane per core, buses sliced per lane.
// Define APPLY_FRONTIER_STALL_CNT_EN to build the per-lane stall-cycle counters.
module apply_frontier_collect
  import apply_frontier_collect_pkg::*;
#(
  parameter int unsigned V_ID_WIDTH = AFC_V_ID_WIDTH,
  parameter int unsigned CORE_NUM   = AFC_CORE_NUM,
  parameter int unsigned FIFO_DEPTH = FRONTIER_FIFO_DEPTH,
  parameter int unsigned AF_MARGIN  = FRONTIER_AF_MARGIN,
  parameter int unsigned CNT_WIDTH  = AFC_CNT_WIDTH,
  parameter int unsigned ITER_WIDTH = AFC_ITER_WIDTH
) (
  input  logic                           clk,
  input  logic [CORE_NUM-1:0]            rst,
  input  logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
  input  logic [CORE_NUM-1:0]            active_v_updated,
  input  logic [CORE_NUM-1:0]            active_v_pull_first_flag,
  input  logic [CORE_NUM-1:0]            active_v_valid,
  input  logic [CORE_NUM-1:0]            iteration_end,
  input  logic [CORE_NUM-1:0]            iteration_end_valid,
  input  logic [CORE_NUM-1:0]            next_frontier_ready,
  output logic [CORE_NUM*V_ID_WIDTH-1:0] next_frontier_v_id,
  output logic [CORE_NUM-1:0]            next_frontier_pull_first_flag,
  output logic [CORE_NUM-1:0]            next_frontier_valid,
  output logic [CORE_NUM-1:0]            front_stall,
  output logic [CORE_NUM-1:0]            iteration_done,
  output logic [CORE_NUM*CNT_WIDTH-1:0]  iteration_update_cnt,
  output logic [CORE_NUM*ITER_WIDTH-1:0] iteration_num,
  output logic [CORE_NUM-1:0]            overflow_err,
  output logic [CORE_NUM*CNT_WIDTH-1:0]  stall_cycle_cnt
);

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_lane
    apply_frontier_collect_lane #(
      .V_ID_WIDTH (V_ID_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_MARGIN  (AF_MARGIN),
      .CNT_WIDTH  (CNT_WIDTH),
      .ITER_WIDTH (ITER_WIDTH)
    ) u_lane (
      .clk                           (clk),
      .rst                           (rst[i]),
      .active_v_id                   (active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
      .active_v_updated              (active_v_updated[i]),
      .active_v_pull_first_flag      (active_v_pull_first_flag[i]),
      .active_v_valid                (active_v_valid[i]),
      .iteration_end                 (iteration_end[i]),
      .iteration_end_valid           (iteration_end_valid[i]),
      .next_frontier_ready           (next_frontier_ready[i]),
      .next_frontier_v_id            (next_frontier_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]),
      .next_frontier_pull_first_flag (next_frontier_pull_first_flag[i]),
      .next_frontier_valid           (next_frontier_valid[i]),
      .front_stall                   (front_stall[i]),
      .iteration_done                (iteration_done[i]),
      .iteration_update_cnt          (iteration_update_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .iteration_num                 (iteration_num[i*ITER_WIDTH +: ITER_WIDTH]),
      .overflow_err                  (overflow_err[i]),
      .stall_cycle_cnt               (stall_cycle_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_apply_frontier_collect.sv
// Bench for apply_frontier_collect: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_apply_frontier_collect;

  localparam int VW     = 16;
  localparam int CN     = 2;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;
  localparam int CW     = 32;
  localparam int IW     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [CN-1:0]    rst;
  logic [CN*VW-1:0] active_v_id;
  logic [CN-1:0]    active_v_updated, active_v_pull_first_flag, active_v_valid;
  logic [CN-1:0]    iteration_end, iteration_end_valid, next_frontier_ready;
  logic [CN*VW-1:0] next_frontier_v_id;
  logic [CN-1:0]    next_frontier_pull_first_flag, next_frontier_valid, front_stall;
  logic [CN-1:0]    iteration_done, overflow_err;
  logic [CN*CW-1:0] iteration_update_cnt, stall_cycle_cnt;
  logic [CN*IW-1:0] iteration_num;

  apply_frontier_collect #(
    .V_ID_WIDTH (VW),
    .CORE_NUM   (CN),
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN  (MARGIN),
    .CNT_WIDTH  (CW),
    .ITER_WIDTH (IW)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .active_v_id                   (active_v_id),
    .active_v_updated              (active_v_updated),
    .active_v_pull_first_flag      (active_v_pull_first_flag),
    .active_v_valid                (active_v_valid),
    .iteration_end                 (iteration_end),
    .iteration_end_valid           (iteration_end_valid),
    .next_frontier_ready           (next_frontier_ready),
    .next_frontier_v_id            (next_frontier_v_id),
    .next_frontier_pull_first_flag (next_frontier_pull_first_flag),
    .next_frontier_valid           (next_frontier_valid),
    .front_stall                   (front_stall),
    .iteration_done                (iteration_done),
    .iteration_update_cnt          (iteration_update_cnt),
    .iteration_num                 (iteration_num),
    .overflow_err                  (overflow_err),
    .stall_cycle_cnt               (stall_cycle_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int lane, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %0d, expected %0d (t=%0t)", name, lane, act, exp, $time);
  endtask

  // Reference model: frontier as a queue of {flag,id}; phase 0=collecting, 1=waiting for drain,
  // 2=completion cycle.
  logic [VW:0]     m_q [CN][$];
  int              m_phase [CN];
  longint unsigned m_upd [CN];
  longint unsigned m_iter [CN];
  longint unsigned m_stall [CN];
  bit              m_ovf [CN];

  task automatic model_reset(input int i);
    m_q[i].delete();
    m_phase[i] = 0;
    m_upd[i]   = 0;
    m_iter[i]  = 0;
    m_stall[i] = 0;
    m_ovf[i]   = 0;
  endtask

  task automatic model_step(input int i);
    int sz;
    bit push, pop, acc;
    sz   = m_q[i].size();
    push = active_v_valid[i] && active_v_updated[i];
    pop  = (sz > 0) && next_frontier_ready[i];
    acc  = push && ((sz < DEPTH) || pop);
    if (push && !acc) m_ovf[i] = 1;
    if (sz > 0 && !next_frontier_ready[i] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
    if (pop) void'(m_q[i].pop_front());
    if (acc) m_q[i].push_back({active_v_pull_first_flag[i], active_v_id[i*VW +: VW]});
    if (m_phase[i] == 2) begin
      m_upd[i]   = acc ? 1 : 0;
      m_phase[i] = 0;
    end else begin
      if (acc && m_upd[i] < 64'hFFFF_FFFF) m_upd[i]++;
      if (m_phase[i] == 0 && iteration_end_valid[i] && iteration_end[i]) m_phase[i] = 1;
      else if (m_phase[i] == 1 && sz == 0 && !push) begin
        m_phase[i] = 2;
        m_iter[i]  = (m_iter[i] + 1) % (64'd1 << IW);
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < CN; i++) begin
      if (rst[i]) model_reset(i);
      else        model_step(i);
    end
  end

  // Observed pops and completions on lane 0 for the literal checks.
  logic [VW-1:0] pop0 [$];
  int            done_seen0 = 0;
  logic [CW-1:0] last_done_cnt0 = '0;

  always @(negedge clk) begin
    for (int i = 0; i < CN; i++) begin
      logic [VW:0] hd;
      bit          ev;
      if (rst[i]) model_reset(i);
      ev = (m_q[i].size() != 0);
      chk("valid", i, 64'(next_frontier_valid[i]), 64'(ev));
      if (ev) begin
        hd = m_q[i][0];
        chk("head_id", i, 64'(next_frontier_v_id[i*VW +: VW]), 64'(hd[VW-1:0]));
        chk("head_flag", i, 64'(next_frontier_pull_first_flag[i]), 64'(hd[VW]));
      end
      chk("front_stall", i, 64'(front_stall[i]), 64'(m_q[i].size() >= DEPTH - MARGIN));
      chk("done", i, 64'(iteration_done[i]), 64'(m_phase[i] == 2));
      if (m_phase[i] == 2) chk("update_cnt", i, 64'(iteration_update_cnt[i*CW +: CW]), m_upd[i]);
      chk("iter_num", i, 64'(iteration_num[i*IW +: IW]), m_iter[i]);
      chk("overflow", i, 64'(overflow_err[i]), 64'(m_ovf[i]));
`ifdef APPLY_FRONTIER_STALL_CNT_EN
      chk("stall_cnt", i, 64'(stall_cycle_cnt[i*CW +: CW]), m_stall[i]);
`else
      chk("stall_cnt", i, 64'(stall_cycle_cnt[i*CW +: CW]), 64'd0);
`endif
    end
    if (next_frontier_valid[0] && next_frontier_ready[0]) pop0.push_back(next_frontier_v_id[VW-1:0]);
    if (iteration_done[0]) begin
      done_seen0++;
      last_done_cnt0 = iteration_update_cnt[CW-1:0];
    end
  end

  // Same stimulus on every lane; lane l sees id + 100*l so bus slicing is exercised.
  task automatic cyc(input bit v, input bit u, input int id, input bit fl, input bit ie,
                     input bit iev, input bit rdy);
    for (int l = 0; l < CN; l++) begin
      active_v_valid[l]             = v;
      active_v_updated[l]           = u;
      active_v_id[l*VW +: VW]       = VW'(id + 100 * l);
      active_v_pull_first_flag[l]   = fl;
      iteration_end[l]              = ie;
      iteration_end_valid[l]        = iev;
      next_frontier_ready[l]        = rdy;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [CW-1:0] s0, s1;
    logic [VW-1:0] pv;
    rst = '1;
    active_v_id = '0; active_v_updated = '0; active_v_pull_first_flag = '0;
    active_v_valid = '0; iteration_end = '0; iteration_end_valid = '0; next_frontier_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, 64'(next_frontier_valid), 64'd0);
    chk("rst_update_cnt", 0, 64'(iteration_update_cnt), 64'd0);
    chk("rst_stall", 0, 64'(front_stall), 64'd0);
    rst = '0;

    // Reset lane 0 in DRAIN with 5 queued; lane 1 must be untouched.
    for (int k = 0; k < 5; k++) cyc(1, 1, 10 + k, k[0], 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 2'b01;
    #2;
    chk("midrst_valid", 0, 64'(next_frontier_valid[0]), 64'd0);
    chk("midrst_update_cnt", 0, 64'(iteration_update_cnt[CW-1:0]), 64'd0);
    chk("midrst_iter_num", 0, 64'(iteration_num[IW-1:0]), 64'd0);
    chk("midrst_other_lane_valid", 1, 64'(next_frontier_valid[1]), 64'd1);
    @(posedge clk);
    #1;
    rst = '0;
    repeat (8) cyc(0, 0, 0, 0, 0, 0, 1);

    // Filtered pushes 3,7,(5 not updated),9 then iteration end.
    pop0.delete();
    d0 = done_seen0;
    cyc(1, 1, 3, 1, 0, 0, 1);
    cyc(1, 1, 7, 0, 0, 0, 1);
    cyc(1, 0, 5, 1, 0, 0, 1);
    cyc(1, 1, 9, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("filt_pop_count", 0, 64'(pop0.size()), 64'd3);
    if (pop0.size() == 3) begin
      pv = pop0[0]; chk("filt_pop0", 0, 64'(pv), 64'd3);
      pv = pop0[1]; chk("filt_pop1", 0, 64'(pv), 64'd7);
      pv = pop0[2]; chk("filt_pop2", 0, 64'(pv), 64'd9);
    end
    chk("filt_done_pulses", 0, 64'(done_seen0 - d0), 64'd1);
    chk("filt_done_cnt", 0, 64'(last_done_cnt0), 64'd3);
    chk("filt_iter_num", 0, 64'(iteration_num[IW-1:0]), 64'd1);

    // Fill to 16 with no ready; stall asserts at count 12.
    pop0.delete();
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, 20 + k, 0, 0, 0, 0);
      if (k == 10) chk("af_at_11", 0, 64'(front_stall[0]), 64'd0);
      if (k == 11) chk("af_at_12", 0, 64'(front_stall[0]), 64'd1);
    end
    // Full: push and pop together both succeed.
    cyc(1, 1, 36, 1, 0, 0, 1);
    chk("full_pushpop_ovf", 0, 64'(overflow_err[0]), 64'd0);
    chk("full_pushpop_stall", 0, 64'(front_stall[0]), 64'd1);
    // Full, no pop: dropped.
    cyc(1, 1, 37, 0, 0, 0, 0);
    chk("full_drop_ovf", 0, 64'(overflow_err[0]), 64'd1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    repeat (20) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("full_pop_count", 0, 64'(pop0.size()), 64'd17);
    if (pop0.size() == 17) begin
      pv = pop0[0];  chk("full_pop_first", 0, 64'(pv), 64'd20);
      pv = pop0[15]; chk("full_pop_15", 0, 64'(pv), 64'd35);
      pv = pop0[16]; chk("full_pop_last", 0, 64'(pv), 64'd36);
    end
    // 16 fills plus the push that rode along with a pop; the dropped 37 does not count.
    chk("full_done_cnt", 0, 64'(last_done_cnt0), 64'd17);
    chk("full_iter_num", 0, 64'(iteration_num[IW-1:0]), 64'd2);

    // Empty iteration: done two cycles after iteration_end, count 0.
    d0 = done_seen0;
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("empty_done_c1", 0, 64'(iteration_done[0]), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("empty_done_c2", 0, 64'(iteration_done[0]), 64'd1);
    chk("empty_update_cnt", 0, 64'(iteration_update_cnt[CW-1:0]), 64'd0);
    chk("empty_iter_num", 0, 64'(iteration_num[IW-1:0]), 64'd3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("empty_done_c3", 0, 64'(iteration_done[0]), 64'd0);
    // Qualifier without iteration_end must not start a drain.
    cyc(0, 0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ie0_done_pulses", 0, 64'(done_seen0 - d0), 64'd1);
    chk("ie0_iter_num", 0, 64'(iteration_num[IW-1:0]), 64'd3);

    // Stall counter: one entry held for 10 cycles with ready low.
    cyc(1, 1, 60, 0, 0, 0, 0);
    s0 = stall_cycle_cnt[CW-1:0];
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
    s1 = stall_cycle_cnt[CW-1:0];
`ifdef APPLY_FRONTIER_STALL_CNT_EN
    chk("stall_delta", 0, 64'(s1 - s0), 64'd10);
`else
    chk("stall_off", 0, 64'(s1), 64'd0);
`endif
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
